// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered onto the ALU. The result is captured after a per-op latency and
// is held on a shared response bus until the owning requester consumes it.
module alu_arbiter #(
  parameter int WIDTH    = 64,
  parameter int LAT_FAST = 1,
  parameter int LAT_SLOW = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [2:0]       req_sel_0,

  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [2:0]       req_sel_1,

  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_o,
  output logic             rsp_err,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_o
);

  localparam int LAT_MAX = (LAT_FAST > LAT_SLOW) ? LAT_FAST : LAT_SLOW;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(LAT_FAST - 1);
  localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(LAT_SLOW - 1);

  localparam logic [2:0] SEL_MUL = 3'b010;
  localparam logic [2:0] SEL_DIV = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [CNT_W-1:0] cnt;

  logic             grant;
  logic             any_valid;
  logic             take;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic [2:0]       pick_sel;
  logic             pick_illegal;
  logic             pick_div0;
  logic             pick_slow;
  logic             owner_ready;

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    any_valid = req_valid_0 | req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid_1;
    end
  end

  assign req_ready_0 = rst_n & (state == IDLE) & req_valid_0 & ~grant;
  assign req_ready_1 = rst_n & (state == IDLE) & req_valid_1 & grant;
  assign take        = (state == IDLE) & any_valid;

  always_comb begin
    pick_a   = grant ? req_a_1   : req_a_0;
    pick_b   = grant ? req_b_1   : req_b_0;
    pick_sel = grant ? req_sel_1 : req_sel_0;
  end

  assign pick_illegal = pick_sel[2] & pick_sel[1];
  assign pick_div0    = (pick_sel == SEL_DIV) && (pick_b == '0);
  assign pick_slow    = (pick_sel == SEL_MUL) || (pick_sel == SEL_DIV);
  assign owner_ready  = owner ? rsp_ready_1 : rsp_ready_0;

  // Error ops bypass EXEC and answer with a fixed result the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_result  <= '0;
      rsp_z       <= 1'b0;
      rsp_o       <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            owner   <= grant;
            alu_a   <= pick_a;
            alu_b   <= pick_b;
            alu_sel <= pick_sel;
            cnt     <= pick_slow ? CNT_SLOW : CNT_FAST;
            if (pick_illegal || pick_div0) begin
              state       <= RESP;
              rsp_result  <= pick_illegal ? '0 : '1;
              rsp_z       <= pick_illegal;
              rsp_o       <= 1'b0;
              rsp_err     <= 1'b1;
              rsp_valid_0 <= ~grant;
              rsp_valid_1 <= grant;
            end else begin
              state <= EXEC;
            end
          end
        end

        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state       <= RESP;
            rsp_result  <= alu_result;
            rsp_z       <= ~|alu_result;
            rsp_o       <= alu_o;
            rsp_err     <= 1'b0;
            rsp_valid_0 <= ~owner;
            rsp_valid_1 <= owner;
          end
        end

        RESP: begin
          if (owner_ready) begin
            state       <= IDLE;
            last_grant  <= owner;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of arbitration, latency and ALU results.
module tb_alu_arbiter;

  localparam int W  = 64;
  localparam int LF = 1;
  localparam int LS = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [2:0]   req_sel_0, req_sel_1;
  logic         rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
  logic [W-1:0] rsp_result;
  logic         rsp_z, rsp_o, rsp_err;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_sel;
  logic         alu_o;

  int comps = 0;
  int fails = 0;
  int last_served;

  bit           have [2];
  bit           rr   [2];
  logic [2:0]   op_sel [2];
  logic [W-1:0] op_a [2];
  logic [W-1:0] op_b [2];

  alu_arbiter #(.WIDTH(W), .LAT_FAST(LF), .LAT_SLOW(LS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_sel_0(req_sel_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .req_sel_1(req_sel_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_o(rsp_o), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_o(alu_o)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: overflow is signed for ADD/SUB and unsigned product loss for MUL.
  always_comb begin
    logic [W-1:0] r;
    r     = '0;
    alu_o = 1'b0;
    case (alu_sel)
      3'b000: begin
        r     = alu_a + alu_b;
        alu_o = (alu_a[W-1] == alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
      end
      3'b001: begin
        r     = alu_a - alu_b;
        alu_o = (alu_a[W-1] != alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
      end
      3'b010: begin
        r     = alu_a * alu_b;
        alu_o = (alu_a != '0) && ((r / alu_a) != alu_b);
      end
      3'b011: r = (alu_b != '0) ? alu_a / alu_b : '1;
      3'b100: r = alu_a & alu_b;
      3'b101: r = alu_a | alu_b;
      default: r = '0;
    endcase
    alu_result = r;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus();
    req_valid_0 = have[0]; req_a_0 = op_a[0]; req_b_0 = op_b[0]; req_sel_0 = op_sel[0];
    req_valid_1 = have[1]; req_a_1 = op_a[1]; req_b_1 = op_b[1]; req_sel_1 = op_sel[1];
    rsp_ready_0 = rr[0];
    rsp_ready_1 = rr[1];
  endtask

  task automatic load_op(input int r, input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    have[r]   = 1'b1;
    op_sel[r] = s;
    op_a[r]   = a;
    op_b[r]   = b;
  endtask

  function automatic logic ready_of(input int r);
    return (r == 1) ? req_ready_1 : req_ready_0;
  endfunction

  function automatic logic valid_of(input int r);
    return (r == 1) ? rsp_valid_1 : rsp_valid_0;
  endfunction

  // Expected response and the number of falling edges from accept until rsp_valid is seen.
  task automatic model_op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic o, output logic err, output int edges);
    logic signed [W:0]  wide;
    logic [2*W-1:0]     prod;
    o   = 1'b0;
    err = 1'b0;
    res = '0;
    edges = LF + 1;
    case (s)
      3'd0: begin
        wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
        res  = wide[W-1:0];
        o    = wide[W] ^ wide[W-1];
      end
      3'd1: begin
        wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
        res  = wide[W-1:0];
        o    = wide[W] ^ wide[W-1];
      end
      3'd2: begin
        prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        res   = prod[W-1:0];
        o     = |prod[2*W-1:W];
        edges = LS + 1;
      end
      3'd3: begin
        if (b == '0) begin
          res   = '1;
          err   = 1'b1;
          edges = 1;
        end else begin
          res   = a / b;
          edges = LS + 1;
        end
      end
      3'd4: res = a & b;
      3'd5: res = a | b;
      default: begin
        res   = '0;
        err   = 1'b1;
        edges = 1;
      end
    endcase
  endtask

  // One complete transaction for whichever pending requester should win arbitration.
  task automatic serve_one(input int hold);
    int           g, o, n, exp_n;
    logic [W-1:0] er;
    logic         eo, ee;
    apply_stimulus();
    #1;
    if (have[0] && have[1]) g = 1 - last_served;
    else if (have[0])       g = 0;
    else                    g = 1;
    o = 1 - g;
    check_output($sformatf("grant_ready_%0d", g), W'(ready_of(g)), W'(1));
    check_output($sformatf("other_ready_%0d", o), W'(ready_of(o)), W'(0));
    model_op(op_sel[g], op_a[g], op_b[g], er, eo, ee, exp_n);
    rr[g] = 1'b0;
    rr[o] = 1'b1;
    apply_stimulus();
    @(posedge clk);
    #1;
    have[g] = 1'b0;
    apply_stimulus();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check_output("busy_ready", W'({req_ready_0, req_ready_1}), W'(0));
    end while (!valid_of(g) && n < 20);
    check_output("rsp_latency", W'(n), W'(exp_n));
    check_output("rsp_valid_other", W'(valid_of(o)), W'(0));
    check_output("rsp_result", rsp_result, er);
    check_output("rsp_z", W'(rsp_z), W'(er == '0));
    check_output("rsp_o", W'(rsp_o), W'(eo));
    check_output("rsp_err", W'(rsp_err), W'(ee));
    check_output("alu_a", alu_a, op_a[g]);
    check_output("alu_b", alu_b, op_b[g]);
    check_output("alu_sel", W'(alu_sel), W'(op_sel[g]));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_output("hold_valid", W'(valid_of(g)), W'(1));
      check_output("hold_result", rsp_result, er);
      check_output("hold_ready", W'({req_ready_0, req_ready_1}), W'(0));
    end
    rr[g] = 1'b1;
    apply_stimulus();
    @(posedge clk);
    #1;
    rr[0] = 1'b0;
    rr[1] = 1'b0;
    apply_stimulus();
    check_output("rsp_valid_drop", W'({rsp_valid_0, rsp_valid_1}), W'(0));
    last_served = g;
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 1000));
      1:       return {$urandom, $urandom};
      2:       return '0;
      default: return {$urandom, $urandom} | {1'b1, {(W-1){1'b0}}};
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ctrl"}, W'({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
                                     rsp_z, rsp_o, rsp_err, alu_sel}), W'(0));
    check_output({tag, "_result"}, rsp_result, '0);
    check_output({tag, "_alu_a"}, alu_a, '0);
    check_output({tag, "_alu_b"}, alu_b, '0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rs;
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      have[r] = 1'b0; rr[r] = 1'b0; op_sel[r] = '0; op_a[r] = '0; op_b[r] = '0;
    end
    last_served = 1;
    apply_stimulus();
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    $display("[TB] ADD from requester 0");
    load_op(0, 3'd0, W'(5), W'(7));
    serve_one(0);

    $display("[TB] simultaneous SUB and MUL");
    load_op(0, 3'd1, W'(3), W'(3));
    load_op(1, 3'd2, W'(6), W'(7));
    serve_one(0);
    serve_one(0);

    $display("[TB] continuous contention alternates grants");
    load_op(0, 3'd4, W'(32'hFF00), W'(32'h0FF0));
    load_op(1, 3'd0, '1, W'(1));
    for (int i = 0; i < 4; i++) begin
      serve_one(0);
      load_op(last_served, 3'd5, W'(i), W'(i * 16));
    end
    serve_one(0);
    serve_one(0);

    $display("[TB] OR with delayed response consumption");
    load_op(1, 3'd5, W'(8'hF0), W'(8'h0F));
    serve_one(5);

    $display("[TB] divide by zero and illegal select");
    load_op(0, 3'd3, W'(99), '0);
    serve_one(0);
    load_op(0, 3'b111, W'(4), W'(5));
    serve_one(1);

    $display("[TB] reset during MUL execution");
    load_op(0, 3'd2, W'(6), W'(7));
    apply_stimulus();
    #1;
    check_output("mul_accept", W'(req_ready_0), W'(1));
    @(posedge clk);
    #1;
    have[0] = 1'b0;
    apply_stimulus();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_exec_reset");
    @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_output("no_stale_rsp", W'({rsp_valid_0, rsp_valid_1}), W'(0));
    end
    load_op(0, 3'd0, W'(100), W'(23));
    serve_one(0);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!have[r] && $urandom_range(0, 1) == 1) begin
          rs = 3'($urandom_range(0, 7));
          ra = rand_word();
          rb = ($urandom_range(0, 4) == 0) ? '0 : rand_word();
          load_op(r, rs, ra, rb);
        end
      end
      if (!have[0] && !have[1]) load_op(0, 3'($urandom_range(0, 5)), rand_word(), rand_word());
      serve_one($urandom_range(0, 3));
    end
    while (have[0] || have[1]) serve_one(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
